// File: rtl/debug_access_ctrl.sv
// debug_access_ctrl: command-driven debug master for the CPU test port.
// Ports: clk, reset (async, active-low); cmd_* host command channel (valid/ready);
//   rsp_* response channel (valid/ready); cpu_test/cpu_rst/cpu_resetpc/cpu_fetch CPU
//   run control; mem_* and reg_* memory and register-file test ports.
module debug_access_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int REG_AW  = 4,
    parameter int CNT_W   = 16,
    parameter int MEM_LAT = 1,
    parameter int REG_LAT = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              cpu_test,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] cpu_resetpc,
    input  logic              cpu_fetch,
    output logic              mem_op,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_op,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata
);

    localparam logic [2:0] OP_RDMEM = 3'd0;
    localparam logic [2:0] OP_WRMEM = 3'd1;
    localparam logic [2:0] OP_RDREG = 3'd2;
    localparam logic [2:0] OP_WRREG = 3'd3;
    localparam logic [2:0] OP_RUN   = 3'd4;

    // One timer serves both the access latency wait and the RUN watchdog.
    localparam int TW = $clog2(TIMEOUT + MEM_LAT + REG_LAT + 2);
    localparam logic [TW-1:0] MEM_END = TW'(MEM_LAT);
    localparam logic [TW-1:0] REG_END = TW'(REG_LAT);
    localparam logic [TW-1:0] WD_END  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, MACC, RACC, VERIFY, RUNRST, RUN, RESP
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [TW-1:0]     timer_q;
    logic [CNT_W:0]    fcnt_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic              accept;
    logic              cmd_mem, cmd_reg, cmd_run, cmd_zero;
    logic              is_mem, is_wr;
    logic              lat_done, fetch_done, wd_expired;
    logic [CNT_W:0]    n_ext;
    logic [CNT_W:0]    done_cnt;
    logic [DATA_W-1:0] rdata;

    assign cmd_mem  = (cmd_op == OP_RDMEM) || (cmd_op == OP_WRMEM);
    assign cmd_reg  = (cmd_op == OP_RDREG) || (cmd_op == OP_WRREG);
    assign cmd_run  = (cmd_op == OP_RUN);
    assign cmd_zero = (cmd_data[CNT_W-1:0] == '0);
    assign accept   = cmd_valid && (state_q == IDLE);

    assign is_mem = (op_q == OP_RDMEM) || (op_q == OP_WRMEM);
    assign is_wr  = (op_q == OP_WRMEM) || (op_q == OP_WRREG);
    assign rdata  = is_mem ? mem_rdata : reg_rdata;

    assign lat_done = (timer_q == (is_mem ? MEM_END : REG_END));

    // Pulse N+1 marks completion of instruction N; compare in CNT_W+1 bits
    // so N = 2^CNT_W-1 does not wrap.
    assign n_ext      = {1'b0, data_q[CNT_W-1:0]};
    assign fetch_done = cpu_fetch && (fcnt_q == n_ext);
    assign wd_expired = !cpu_fetch && (timer_q == WD_END);
    assign done_cnt   = (fcnt_q == '0) ? '0 : fcnt_q - 1'b1;

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        cpu_test    = 1'b0;
        cpu_rst     = 1'b0;
        cpu_resetpc = '0;
        mem_op      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        reg_op      = 1'b0;
        reg_we      = 1'b0;
        reg_addr    = '0;
        reg_wdata   = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    unique case (1'b1)
                        cmd_mem: state_d = MACC;
                        cmd_reg: state_d = RACC;
                        cmd_run: state_d = cmd_zero ? RESP : RUNRST;
                        default: state_d = RESP;
                    endcase
                end
            end
            MACC: begin
                mem_op    = 1'b1;
                mem_we    = is_wr;
                mem_addr  = addr_q;
                mem_wdata = data_q;
                // A write commits on its single we cycle, then is read back.
                if (is_wr)         state_d = VERIFY;
                else if (lat_done) state_d = RESP;
            end
            RACC: begin
                reg_op    = 1'b1;
                reg_we    = is_wr;
                reg_addr  = addr_q[REG_AW-1:0];
                reg_wdata = data_q;
                if (is_wr)         state_d = VERIFY;
                else if (lat_done) state_d = RESP;
            end
            VERIFY: begin
                if (is_mem) begin
                    mem_op    = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = data_q;
                end else begin
                    reg_op    = 1'b1;
                    reg_addr  = addr_q[REG_AW-1:0];
                    reg_wdata = data_q;
                end
                if (lat_done) state_d = RESP;
            end
            RUNRST: begin
                cpu_test    = 1'b1;
                cpu_rst     = 1'b1;
                cpu_resetpc = addr_q;
                state_d     = RUN;
            end
            RUN: begin
                cpu_test = 1'b1;
                if (fetch_done || wd_expired) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            timer_q    <= '0;
            fcnt_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (state_d != state_q)
                timer_q <= '0;
            else if (state_q == RUN && cpu_fetch)
                timer_q <= '0;
            else if (state_q != IDLE && state_q != RESP)
                timer_q <= timer_q + 1'b1;

            if (accept) begin
                op_q   <= cmd_op;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                fcnt_q <= '0;
                if (!cmd_mem && !cmd_reg) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= !cmd_run;
                end
            end

            if ((state_q == MACC || state_q == RACC) && !is_wr && lat_done) begin
                rsp_data_q <= rdata;
                rsp_err_q  <= 1'b0;
            end

            if (state_q == VERIFY && lat_done) begin
                rsp_data_q <= rdata;
                rsp_err_q  <= (rdata != data_q);
            end

            if (state_q == RUN) begin
                if (cpu_fetch) fcnt_q <= fcnt_q + 1'b1;
                if (fetch_done) begin
                    rsp_data_q <= DATA_W'(data_q[CNT_W-1:0]);
                    rsp_err_q  <= 1'b0;
                end else if (wd_expired) begin
                    rsp_data_q <= DATA_W'(done_cnt);
                    rsp_err_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_access_ctrl.sv
// tb_debug_access_ctrl: directed bench for debug_access_ctrl with memory,
//   register-file and fetch-pulse models standing in for the CPU system.
module tb_debug_access_ctrl;

    localparam int TO = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        cpu_test;
    logic        cpu_rst;
    logic [15:0] cpu_resetpc;
    logic        cpu_fetch = 1'b0;
    logic        mem_op, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        reg_op, reg_we;
    logic [3:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = '0;

    int total = 0;
    int bad = 0;

    debug_access_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cpu_test(cpu_test), .cpu_rst(cpu_rst),
        .cpu_resetpc(cpu_resetpc), .cpu_fetch(cpu_fetch),
        .mem_op(mem_op), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .reg_op(reg_op), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    // Memory: 1-cycle read latency, bit 0 of address 4 stuck at 0.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_op) begin
            if (mem_we)
                mem[mem_addr[7:0]] <= (mem_addr == 16'd4) ?
                    {mem_wdata[15:1], 1'b0} : mem_wdata;
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // Register file: 2-cycle read latency.
    logic [15:0] regs [0:15];
    logic [15:0] rstage = '0;
    always @(posedge clk) begin
        if (reg_op && reg_we) regs[reg_addr] <= reg_wdata;
        rstage    <= regs[reg_addr];
        reg_rdata <= rstage;
    end

    // CPU stand-in: a fetch pulse every 3rd cycle while running.
    logic fetch_en = 1'b0;
    int   fetch_stop = 1000000;
    int   ph = 0;
    int   npulse = 0;
    int   nrst = 0;
    int   nwe = 0;
    int   nact = 0;
    int   nboth = 0;
    logic [15:0] last_pc = '0;
    always @(posedge clk) begin
        if (!cpu_test || cpu_rst) begin
            ph        <= 0;
            cpu_fetch <= 1'b0;
        end else begin
            ph        <= (ph == 2) ? 0 : ph + 1;
            cpu_fetch <= fetch_en && (ph == 2) && (npulse < fetch_stop);
        end
        if (cpu_fetch && cpu_test) npulse <= npulse + 1;
        if (cpu_rst) begin
            nrst    <= nrst + 1;
            last_pc <= cpu_resetpc;
        end
        if (mem_we) nwe <= nwe + 1;
        if (mem_op || reg_op || cpu_test || cpu_rst) nact <= nact + 1;
        if (mem_op && reg_op) nboth <= nboth + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold, output logic [15:0] d,
                           output logic e, output logic tst, output int cyc);
        int n = 0;
        logic [15:0] d0;
        rsp_ready = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 3000);
        cyc = n;
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        d0 = rsp_data;
        repeat (hold) @(negedge clk);
        if (hold > 0) chk("rsp_hold", {15'd0, rsp_valid, rsp_data}, {15'd0, 1'b1, d0});
        d = rsp_data; e = rsp_err; tst = cpu_test;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {23'd0, cmd_ready, rsp_valid, rsp_err, cpu_test,
            cpu_rst, mem_op, mem_we, reg_op, reg_we}, 32'h100);
        chk({tag, "_rsp"}, {16'd0, rsp_data}, 32'd0);
        chk({tag, "_mem"}, {mem_addr, mem_wdata}, 32'd0);
        chk({tag, "_reg"}, {12'd0, reg_addr, reg_wdata}, 32'd0);
        chk({tag, "_pc"}, {16'd0, cpu_resetpc}, 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        logic e, t;
        int cyc, p0, r0, w0, a0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) regs[i] = '0;

        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset = 1'b1;

        // Write memory with verify
        w0 = nwe;
        send(3'd1, 16'h0001, 16'h70ff);
        get_rsp(0, d, e, t, cyc);
        chk("wrmem1_data", {16'd0, d}, 32'h70ff);
        chk("wrmem1_err", {31'd0, e}, 32'd0);
        chk("wrmem1_we_pulses", nwe - w0, 32'd1);
        chk("wrmem1_model", {16'd0, mem[1]}, 32'h70ff);

        send(3'd1, 16'h0002, 16'h7105);
        get_rsp(0, d, e, t, cyc);
        chk("wrmem2", {15'd0, e, d}, {15'd0, 1'b0, 16'h7105});

        send(3'd0, 16'h0001, 16'h0000);
        get_rsp(0, d, e, t, cyc);
        chk("rdmem1", {15'd0, e, d}, {15'd0, 1'b0, 16'h70ff});
        chk("rdmem_latency", cyc, 32'd3);

        // Register writes/reads
        send(3'd3, 16'h0001, 16'h0002);
        get_rsp(0, d, e, t, cyc);
        chk("wrreg1", {15'd0, e, d}, {15'd0, 1'b0, 16'h0002});
        send(3'd3, 16'h0003, 16'h0010);
        get_rsp(0, d, e, t, cyc);
        chk("wrreg3", {15'd0, e, d}, {15'd0, 1'b0, 16'h0010});
        send(3'd2, 16'h0001, 16'h0000);
        get_rsp(0, d, e, t, cyc);
        chk("rdreg1", {15'd0, e, d}, {15'd0, 1'b0, 16'h0002});
        chk("rdreg_latency", cyc, 32'd4);

        // Busy: second command ignored
        w0 = nwe;
        send(3'd2, 16'h0003, 16'h0000);
        cmd_op = 3'd1; cmd_addr = 16'h0005; cmd_data = 16'hbeef;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("busy_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        get_rsp(0, d, e, t, cyc);
        chk("rdreg3", {15'd0, e, d}, {15'd0, 1'b0, 16'h0010});
        chk("busy_no_write", {nwe - w0, mem[5]}, 48'd0);

        // Stuck-bit verify error
        send(3'd1, 16'h0004, 16'h0001);
        get_rsp(0, d, e, t, cyc);
        chk("stuck_verify", {15'd0, e, d}, {15'd0, 1'b1, 16'h0000});

        // RUN N=2 from address 1
        fetch_en = 1'b1; p0 = npulse; r0 = nrst;
        send(3'd4, 16'h0001, 16'h0002);
        get_rsp(0, d, e, t, cyc);
        chk("run2_rsp", {15'd0, e, d}, {15'd0, 1'b0, 16'd2});
        chk("run2_pulses", npulse - p0, 32'd3);
        chk("run2_rst", nrst - r0, 32'd1);
        chk("run2_pc", {16'd0, last_pc}, 32'h0001);
        chk("run2_test_off", {31'd0, t}, 32'd0);

        // RUN N=1 from address 0x10
        p0 = npulse;
        send(3'd4, 16'h0010, 16'h0001);
        get_rsp(0, d, e, t, cyc);
        chk("run1_rsp", {15'd0, e, d}, {15'd0, 1'b0, 16'd1});
        chk("run1_pulses", npulse - p0, 32'd2);
        chk("run1_pc", {16'd0, last_pc}, 32'h0010);

        // RUN N=0 responds directly
        r0 = nrst;
        send(3'd4, 16'h0020, 16'h0000);
        get_rsp(0, d, e, t, cyc);
        chk("run0_rsp", {15'd0, e, d}, {15'd0, 1'b0, 16'd0});
        chk("run0_latency", cyc, 32'd1);
        chk("run0_no_rst", nrst - r0, 32'd0);

        // Watchdog after 3 instructions begin
        fetch_stop = npulse + 3;
        send(3'd4, 16'h0001, 16'd10);
        get_rsp(0, d, e, t, cyc);
        chk("wd_partial", {15'd0, e, d}, {15'd0, 1'b1, 16'd2});
        fetch_stop = 1000000;

        // Watchdog with no fetch at all
        fetch_en = 1'b0;
        send(3'd4, 16'h0001, 16'd5);
        get_rsp(0, d, e, t, cyc);
        chk("wd_none", {14'd0, t, e, d}, {14'd0, 1'b0, 1'b1, 16'd0});
        chk("wd_time", {31'd0, (cyc >= TO) && (cyc <= TO + 4)}, 32'd1);

        // Illegal op, response held a few cycles
        a0 = nact;
        send(3'd6, 16'h0003, 16'h1234);
        get_rsp(3, d, e, t, cyc);
        chk("illegal_rsp", {15'd0, e, d}, {15'd0, 1'b1, 16'd0});
        chk("illegal_latency", cyc, 32'd1);
        chk("illegal_quiet", nact - a0, 32'd0);

        // Reset during RUN
        fetch_en = 1'b1;
        send(3'd4, 16'h0001, 16'd50);
        repeat (15) @(negedge clk);
        chk("run_active", {31'd0, cpu_test}, 32'd1);
        reset = 1'b0;
        #1 chk_reset("midrun");
        @(negedge clk);
        reset = 1'b1;
        fetch_en = 1'b0;
        send(3'd0, 16'h0002, 16'h0000);
        get_rsp(0, d, e, t, cyc);
        chk("post_reset_rd", {15'd0, e, d}, {15'd0, 1'b0, 16'h7105});

        chk("never_both_ops", nboth, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
